// File: rtl/fpu_cvt_to_float_pipe.sv
// Integer to IEEE-754 binary32 converter (FCVT.S.W/WU/L/LU), three registered stages.
//   S1: sign extraction, absolute value, leading-one position.
//   S2: normalisation to a 24-bit significand plus guard/round/sticky bits.
//   S3: rounding (RNE/RTZ/RDN/RUP/RMM), packing and the inexact flag.
// Ports:
//   clk_i, reset_i (sync, active high), flush_i (drops every in-flight op)
//   in_valid_i/in_ready_o       : issue handshake; is_unsigned_i, is_long_i, rounding_mode_i,
//                                 a_i (operand) and tag_i travel with the op
//   out_valid_o/out_ready_i     : result handshake; result_o, fflags_nx_o and tag_o
//                                 hold steady while stalled
module fpu_cvt_to_float_pipe #(
  parameter int unsigned INT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 is_unsigned_i,
  input  logic                 is_long_i,
  input  logic [2:0]           rounding_mode_i,
  input  logic [INT_WIDTH-1:0] a_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          result_o,
  output logic                 fflags_nx_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  // Stage valids and handshake
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_free, s2_free, s3_free;

  // A stage can take new data when it is empty or its occupant is leaving this cycle.
  assign s3_free    = ~s3_valid_q | out_ready_i;
  assign s2_free    = ~s2_valid_q | s3_free;
  assign s1_free    = ~s1_valid_q | s2_free;
  assign in_ready_o = s1_free;

  // S1: operand preparation
  logic                 long_sel, src_msb, s1_sign_d, s1_zero_d;
  logic [63:0]          a_ext, src, s1_mag_d;
  logic [5:0]           s1_msb_d;
  logic                 s1_sign_q, s1_zero_q;
  logic [63:0]          s1_mag_q;
  logic [5:0]           s1_msb_q;
  logic [2:0]           s1_rm_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;

  always_comb begin
    a_ext     = 64'(a_i);
    long_sel  = is_long_i & (INT_WIDTH == 64);
    src_msb   = long_sel ? a_ext[63] : a_ext[31];
    s1_sign_d = ~is_unsigned_i & src_msb;
    if (long_sel) begin
      src = a_ext;
    end else begin
      src = {{32{s1_sign_d}}, a_ext[31:0]};
    end
    // Unsigned 64-bit space holds |most negative| = 2^63 without overflow.
    s1_mag_d  = s1_sign_d ? (~src + 64'd1) : src;
    s1_zero_d = (s1_mag_d == 64'd0);
    s1_msb_d  = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (s1_mag_d[i]) s1_msb_d = 6'(i);
    end
  end

  // S2: normalisation
  logic [63:0]          shifted;
  logic [23:0]          s2_sig_d;
  logic                 s2_g_d, s2_r_d, s2_s_d;
  logic [7:0]           s2_exp_d;
  logic                 s2_sign_q, s2_zero_q, s2_g_q, s2_r_q, s2_s_q;
  logic [23:0]          s2_sig_q;
  logic [7:0]           s2_exp_q;
  logic [2:0]           s2_rm_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;

  always_comb begin
    shifted  = s1_mag_q << (6'd63 - s1_msb_q);
    s2_sig_d = shifted[63:40];
    s2_g_d   = shifted[39];
    s2_r_d   = shifted[38];
    s2_s_d   = |shifted[37:0];
    s2_exp_d = 8'd127 + {2'b00, s1_msb_q};
  end

  // S3: rounding and packing
  logic                 grs, roundup, unused_hidden;
  logic [24:0]          sum;
  logic [7:0]           exp_r;
  logic [22:0]          frac;
  logic [31:0]          s3_result_d;
  logic                 s3_nx_d;
  logic [31:0]          s3_result_q;
  logic                 s3_nx_q;
  logic [TAG_WIDTH-1:0] s3_tag_q;

  always_comb begin
    grs = s2_g_q | s2_r_q | s2_s_q;
    case (s2_rm_q)
      RmRtz:   roundup = 1'b0;
      RmRdn:   roundup = s2_sign_q & grs;
      RmRup:   roundup = ~s2_sign_q & grs;
      RmRmm:   roundup = s2_g_q;
      default: roundup = s2_g_q & (s2_r_q | s2_s_q | s2_sig_q[0]);  // RNE, also 101..111
    endcase
    sum           = {1'b0, s2_sig_q} + {24'd0, roundup};
    // Carry out means the significand rolled over to 1.0 at the next exponent.
    exp_r         = s2_exp_q + {7'd0, sum[24]};
    frac          = sum[24] ? 23'd0 : sum[22:0];
    unused_hidden = sum[23];
    if (s2_zero_q) begin
      s3_result_d = 32'd0;
      s3_nx_d     = 1'b0;
    end else begin
      s3_result_d = {s2_sign_q, exp_r, frac};
      s3_nx_d     = grs;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_msb_q    <= '0;
      s1_rm_q     <= '0;
      s1_tag_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_g_q      <= 1'b0;
      s2_r_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_sig_q    <= '0;
      s2_exp_q    <= '0;
      s2_rm_q     <= '0;
      s2_tag_q    <= '0;
      s3_result_q <= '0;
      s3_nx_q     <= 1'b0;
      s3_tag_q    <= '0;
    end else if (flush_i) begin
      // Datapath registers are left alone; only occupancy is cleared.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (s1_free) s1_valid_q <= in_valid_i;
      if (s2_free) s2_valid_q <= s1_valid_q;
      if (s3_free) s3_valid_q <= s2_valid_q;
      if (s1_free && in_valid_i) begin
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        s1_mag_q  <= s1_mag_d;
        s1_msb_q  <= s1_msb_d;
        s1_rm_q   <= rounding_mode_i;
        s1_tag_q  <= tag_i;
      end
      if (s2_free && s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_g_q    <= s2_g_d;
        s2_r_q    <= s2_r_d;
        s2_s_q    <= s2_s_d;
        s2_sig_q  <= s2_sig_d;
        s2_exp_q  <= s2_exp_d;
        s2_rm_q   <= s1_rm_q;
        s2_tag_q  <= s1_tag_q;
      end
      if (s3_free && s2_valid_q) begin
        s3_result_q <= s3_result_d;
        s3_nx_q     <= s3_nx_d;
        s3_tag_q    <= s2_tag_q;
      end
    end
  end

  assign out_valid_o = s3_valid_q;
  assign result_o    = s3_result_q;
  assign fflags_nx_o = s3_nx_q;
  assign tag_o       = s3_tag_q;

endmodule
